switch_debounce_toggle: RTL
===========================

// Module: switch_debounce_toggle
// PURPOSE
//  Conditions raw board switch/button inputs for use by the LED logic: per-channel
//  2-flop synchronizer, counter-based debounce, one-cycle press/release strobes,
//  and a press-toggled LED latch. Sits between the switch pins and LED/gate logic.
// PARAMETERS
//  NUM_SW           2        number of independent switch channels (1..8)
//  DEBOUNCE_CYCLES  240000   consecutive cycles a new level must hold (10 ms @ 24 MHz); >=2
//  ACTIVE_LOW       0        1: pin low = pressed; raw input inverted before synchronizer
// PORTS
//  i_Clk        in   1        system clock (24 MHz on board)
//  i_Rst_n      in   1        asynchronous active-low reset
//  i_Switch     in   NUM_SW   raw, asynchronous switch pins
//  o_Switch_Db  out  NUM_SW   debounced level, 1 = pressed
//  o_Press      out  NUM_SW   1-cycle strobe on debounced 0->1
//  o_Release    out  NUM_SW   1-cycle strobe on debounced 1->0
//  o_LED        out  NUM_SW   toggles on each press of its channel
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. All flops clear on i_Rst_n=0:
//    sync stages, counters, o_Switch_Db, o_Press, o_Release, o_LED all 0. Release
//    needs no synchronizer beyond what the integrator provides.
//  - Polarity: in = ACTIVE_LOW ? ~i_Switch : i_Switch; sync flops reset to 0 (inactive).
//  - Channels fully independent; identical logic per bit.
//  - Per channel: sync1<=in; sync2<=sync1. Counter cnt, width $clog2(DEBOUNCE_CYCLES).
//    * sync2 == stable: cnt<=0.
//    * sync2 != stable, cnt < DEBOUNCE_CYCLES-1: cnt<=cnt+1.
//    * sync2 != stable, cnt == DEBOUNCE_CYCLES-1: stable<=sync2, cnt<=0.
//    Any single cycle where sync2 returns to stable (bounce) restarts count from 0.
//  - Two states per channel: STABLE_LO / STABLE_HI (== stable bit); counter is the
//    qualification timer; no other states.
//  - Latency: clean edge on in -> o_Switch_Db change after exactly 2+DEBOUNCE_CYCLES
//    clock edges. Pulses shorter than DEBOUNCE_CYCLES sync'd cycles never propagate.
//  - o_Press/o_Release registered, asserted in the same cycle o_Switch_Db first
//    shows the new level, high for exactly 1 cycle. Never both high on one channel.
//  - o_LED<=~o_LED on the cycle o_Press is high (visible next cycle).
//  - Simultaneous presses on different channels: each strobes/toggles independently.
//  - Counter never wraps: saturation impossible by the rules above.
//  - Reset mid-qualification: count discarded, channel returns to STABLE_LO, no
//    strobe generated on reset exit even if pin is held pressed; the press then
//    qualifies normally (press strobe after 2+DEBOUNCE_CYCLES).
// STRUCTURE
//  - Shared header board_defs.vh: CLK_HZ=24_000_000, DEBOUNCE_MS=10, derived
//    DEBOUNCE_CYCLES default; no typedefs needed.
//  - Sub-module debounce_channel (sync, counter, stable bit, strobes, LED toggle),
//    instantiated NUM_SW times in a generate loop; top holds polarity inversion only.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, NUM_SW=2, ACTIVE_LOW=0)
//  1 Reset: drive i_Switch=2'b11 during reset -> all outputs 0 while i_Rst_n=0;
//    after release, o_Switch_Db[0]=1 and o_Press[0]=1 exactly 6 cycles later.
//  2 Clean press ch0 at cycle 0 -> o_Switch_Db[0]=1, o_Press[0]=1 at cycle 6 for
//    1 cycle; o_LED[0]=1 from cycle 7; release -> o_Release[0] 1 cycle, LED stays 1.
//  3 Bounce: ch0 pattern 1,0,1,1,0,1,1,1,1 -> no output until 4 consecutive 1s
//    synchronized; single o_Press[0]; 3-cycle glitch alone -> no strobe, no LED change.
//  4 Two presses ch1 -> o_LED[1] 0->1->0; ch0 outputs unchanged throughout.
//  5 Both channels pressed same cycle -> o_Press=2'b11 in one cycle, o_LED=2'b11.
//  6 Assert i_Rst_n=0 at cnt=2 of a qualification -> outputs 0 asynchronously
//    (same cycle), no strobe after reset exit; ACTIVE_LOW=1 rerun of test 2 with
//    inverted pin values gives identical outputs.

Source files
------------

// File: rtl/switch_debounce_toggle_pkg.sv
// Shared board constants and types for the switch debounce / LED toggle block.
// Default qualification time is derived from the board clock and debounce window.
package switch_debounce_toggle_pkg;

  localparam int CLK_HZ                  = 24_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

  // The stable bit doubles as the channel state: it is the debounced level.
  typedef enum logic {
    STABLE_LO = 1'b0,
    STABLE_HI = 1'b1
  } db_state_e;

  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/switch_debounce_toggle_channel.sv
// One switch channel: 2-flop synchronizer, qualification counter, debounced
// level, one-cycle press/release strobes and a press-toggled LED latch.
module debounce_channel
  import switch_debounce_toggle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_In,
  output logic o_Db,
  output logic o_Press,
  output logic o_Release,
  output logic o_LED
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  db_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          r_release;
  logic          r_led;

  db_state_e w_sync_state;
  logic      w_differs;
  logic      w_qualified;

  assign w_sync_state = db_state_e'(r_sync2);
  assign w_differs    = (w_sync_state != r_state);
  assign w_qualified  = w_differs && (r_cnt == CNT_LAST);

  // NOTE: every register here is state updated on the clock, so all use
  // non-blocking assignment; reads on the right-hand side see pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= STABLE_LO;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_led     <= 1'b0;
    end else begin
      r_sync1   <= i_In;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_led     <= r_led ^ r_press;
      if (!w_differs) begin
        // A single cycle back at the stable level restarts qualification.
        r_cnt <= '0;
      end else if (w_qualified) begin
        r_cnt     <= '0;
        r_state   <= w_sync_state;
        r_press   <= r_sync2;
        r_release <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_Db      = r_state;
  assign o_Press   = r_press;
  assign o_Release = r_release;
  assign o_LED     = r_led;

endmodule

// File: rtl/switch_debounce_toggle.sv
// Top: applies pin polarity, then one independent debounce channel per switch.
module switch_debounce_toggle
  import switch_debounce_toggle_pkg::*;
#(
  parameter int NUM_SW          = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Switch_Db,
  output logic [NUM_SW-1:0] o_Press,
  output logic [NUM_SW-1:0] o_Release,
  output logic [NUM_SW-1:0] o_LED
);

  logic [NUM_SW-1:0] w_in;

  assign w_in = ACTIVE_LOW ? ~i_Switch : i_Switch;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .i_Clk    (i_Clk),
      .i_Rst_n  (i_Rst_n),
      .i_In     (w_in[g]),
      .o_Db     (o_Switch_Db[g]),
      .o_Press  (o_Press[g]),
      .o_Release(o_Release[g]),
      .o_LED    (o_LED[g])
    );
  end

endmodule
